// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller: tracks destinations in EX/MEM/WB
// and drives the decode operand mux selects plus a load-use stall.
module fwd_ctrl #(
    parameter int REG_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_we,
    input  logic                issue_load,
    input  logic [REG_BITS-1:0] issue_rd,
    input  logic [REG_BITS-1:0] src_a,
    input  logic [REG_BITS-1:0] src_b,
    input  logic                use_a,
    input  logic                use_b,
    input  logic                flush,
    output logic [1:0]          sel_a,
    output logic [1:0]          sel_b,
    output logic                stall
);

    typedef struct packed {
        logic                valid;
        logic                we;
        logic                load;
        logic [REG_BITS-1:0] rd;
    } slot_t;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    slot_t ex_slot, mem_slot, wb_slot;
    slot_t issue_slot;

    logic ex_a, mem_a, wb_a;
    logic ex_b, mem_b, wb_b;

    function automatic logic slot_match(
        input slot_t               s,
        input logic                use_x,
        input logic [REG_BITS-1:0] src_x
    );
        return use_x && (src_x != '0) && s.valid && s.we && (s.rd == src_x);
    endfunction

    function automatic logic [1:0] pick_sel(
        input logic ex_hit,
        input logic mem_hit,
        input logic wb_hit
    );
        if (ex_hit)       return SEL_EX;
        else if (mem_hit) return SEL_MEM;
        else if (wb_hit)  return SEL_WB;
        else              return SEL_RF;
    endfunction

    assign issue_slot = '{valid: 1'b1, we: issue_we, load: issue_load, rd: issue_rd};

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        ex_a  = 1'b0;
        mem_a = 1'b0;
        wb_a  = 1'b0;
        ex_b  = 1'b0;
        mem_b = 1'b0;
        wb_b  = 1'b0;
        sel_a = SEL_RF;
        sel_b = SEL_RF;
        stall = 1'b0;
        if (!rst && issue_valid) begin
            ex_a  = slot_match(ex_slot,  use_a, src_a);
            mem_a = slot_match(mem_slot, use_a, src_a);
            wb_a  = slot_match(wb_slot,  use_a, src_a);
            ex_b  = slot_match(ex_slot,  use_b, src_b);
            mem_b = slot_match(mem_slot, use_b, src_b);
            wb_b  = slot_match(wb_slot,  use_b, src_b);
            sel_a = pick_sel(ex_a, mem_a, wb_a);
            sel_b = pick_sel(ex_b, mem_b, wb_b);
            stall = ex_slot.load && (ex_a || ex_b);
        end
    end

    // NOTE: state registers use non-blocking assignments so all slots shift from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            // A stalled or flushed instruction leaves a bubble behind in EX.
            if (issue_valid && !stall && !flush) begin
                ex_slot <= issue_slot;
            end else begin
                ex_slot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed self-checking bench for fwd_ctrl: one task per scenario, expected
// values hand-computed from the slot pipeline behaviour.
module tb_fwd_ctrl;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_we;
    logic       issue_load;
    logic [3:0] issue_rd;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic       use_a;
    logic       use_b;
    logic       flush;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       stall;

    int n_cmp;
    int n_bad;

    fwd_ctrl #(.REG_BITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_load  (issue_load),
        .issue_rd    (issue_rd),
        .src_a       (src_a),
        .src_b       (src_b),
        .use_a       (use_a),
        .use_b       (use_b),
        .flush       (flush),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge and are sampled 1 unit later.
    task automatic drive(input logic v, input logic we, input logic ld, input logic [3:0] rd,
                         input logic [3:0] sa, input logic ua, input logic [3:0] sb,
                         input logic ub, input logic fl);
        issue_valid = v;
        issue_we    = we;
        issue_load  = ld;
        issue_rd    = rd;
        src_a       = sa;
        use_a       = ua;
        src_b       = sb;
        use_b       = ub;
        flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0);
        n_cmp++;
        if (sel_a !== 2'd1) begin
            n_bad++; $display("FAIL reset_prefill sel_a got %0d want 1", sel_a);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sel_a !== 2'd0) begin
            n_bad++; $display("FAIL reset_async sel_a got %0d want 0", sel_a);
        end
        n_cmp++;
        if (sel_b !== 2'd0) begin
            n_bad++; $display("FAIL reset_async sel_b got %0d want 0", sel_b);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL reset_async stall got %0d want 0", stall);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (sel_a !== 2'd0) begin
            n_bad++; $display("FAIL reset_release sel_a got %0d want 0", sel_a);
        end
        n_cmp++;
        if (sel_b !== 2'd0) begin
            n_bad++; $display("FAIL reset_release sel_b got %0d want 0", sel_b);
        end
        tick();
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [1:0] want [4];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
        drive(1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
            n_cmp++;
            if (sel_a !== want[c]) begin
                n_bad++; $display("FAIL b2b_cycle%0d sel_a got %0d want %0d", c + 1, sel_a, want[c]);
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_priority();
        drive(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        n_cmp++;
        if (sel_b !== 2'd1) begin
            n_bad++; $display("FAIL prio_ex_over_mem sel_b got %0d want 1", sel_b);
        end
        tick();
        // Writers now in MEM and WB, non-writing reader in EX.
        n_cmp++;
        if (sel_b !== 2'd2) begin
            n_bad++; $display("FAIL prio_mem_over_wb sel_b got %0d want 2", sel_b);
        end
        idle(3);
    endtask

    task automatic test_load_use();
        drive(1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 4'd9, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL loaduse_stall stall got %0d want 1", stall);
        end
        tick();
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL loaduse_release stall got %0d want 0", stall);
        end
        n_cmp++;
        if (sel_a !== 2'd2) begin
            n_bad++; $display("FAIL loaduse_release sel_a got %0d want 2", sel_a);
        end
        n_cmp++;
        if (sel_b !== 2'd0) begin
            n_bad++; $display("FAIL loaduse_bubble sel_b got %0d want 0", sel_b);
        end
        tick();
        n_cmp++;
        if (sel_a !== 2'd3 || sel_b !== 2'd1) begin
            n_bad++; $display("FAIL loaduse_after sel_a/sel_b got %0d/%0d want 3/1", sel_a, sel_b);
        end
        idle(3);
    endtask

    task automatic test_zero_and_unused();
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        n_cmp++;
        if (sel_a !== 2'd0) begin
            n_bad++; $display("FAIL zero_reg sel_a got %0d want 0", sel_a);
        end
        idle(3);
        drive(1'b1, 1'b1, 1'b1, 4'd4, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd4, 1'b0, 1'b0);
        n_cmp++;
        if (sel_b !== 2'd0) begin
            n_bad++; $display("FAIL unused_b sel_b got %0d want 0", sel_b);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL unused_b stall got %0d want 0", stall);
        end
        idle(3);
        drive(1'b1, 1'b1, 1'b1, 4'd8, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd8, 1'b1, 4'd8, 1'b1, 1'b0);
        n_cmp++;
        if (sel_a !== 2'd0 || sel_b !== 2'd0 || stall !== 1'b0) begin
            n_bad++; $display("FAIL invalid_issue sel_a/sel_b/stall got %0d/%0d/%0d want 0/0/0",
                              sel_a, sel_b, stall);
        end
        idle(3);
        drive(1'b1, 1'b0, 1'b0, 4'd10, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd10, 1'b1, 4'd0, 1'b0, 1'b0);
        n_cmp++;
        if (sel_a !== 2'd0) begin
            n_bad++; $display("FAIL nonwriter sel_a got %0d want 0", sel_a);
        end
        idle(3);
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 1'b0, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
        n_cmp++;
        if (sel_a !== 2'd0) begin
            n_bad++; $display("FAIL flush_killed sel_a got %0d want 0", sel_a);
        end
        idle(3);
        // A flush only kills the decoded instruction; older slots keep moving.
        drive(1'b1, 1'b1, 1'b0, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 4'd12, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
        n_cmp++;
        if (sel_a !== 2'd2) begin
            n_bad++; $display("FAIL flush_keeps_mem sel_a got %0d want 2", sel_a);
        end
        idle(3);
        drive(1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 4'd11, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL flush_stall stall got %0d want 1", stall);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 4'd11, 1'b1, 1'b0);
        n_cmp++;
        if (stall !== 1'b0 || sel_a !== 2'd2 || sel_b !== 2'd0) begin
            n_bad++; $display("FAIL flush_stall_after stall/sel_a/sel_b got %0d/%0d/%0d want 0/2/0",
                              stall, sel_a, sel_b);
        end
        idle(3);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_back_to_back();
        test_priority();
        test_load_use();
        test_zero_and_unused();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
